fcs_tx_framer: RTL and testbench
================================

Name: fcs_tx_framer

Overview:
- Transmit-side counterpart of the receive CRC checker.
- Takes a wire-order dibit payload stream for the RMII TX path. Pads short frames to a minimum length, appends the CRC-32 FCS, then enforces an inter-packet gap before accepting the next frame.
- Sits between bitorder_out and ether_out.
- Frames produced here pass the receive cksum check unchanged.

Parameters:
- MIN_PAYLOAD_BYTES, 60, minimum bytes before FCS; 0 disables padding.
- IFG_DIBITS, 48, idle dibit cycles after the last FCS dibit (96 bit times).
- MAX_FRAME_DIBITS, 6072, saturation limit of the dibit counter (1518 bytes).

Ports:
- clk  in  1  RMII 50 MHz reference clock; sole clock.
- rst  in  1  synchronous, active-high reset.
- axiiv  in  1  input dibit valid. Frame = one contiguous high run.
- axiid  in  2  input dibit, wire order; axiid[0] is the earlier bit.
- axiir  out  1  ready; input is accepted only when axiiv & axiir.
- axiov  out  1  output dibit valid, feeds ether_out.
- axiod  out  2  output dibit, wire order.
- frame_done  out  1  one-cycle pulse on the cycle after the last FCS dibit is presented.
- drop_err  out  1  sticky: valid input arrived while axiir was low.
- led  out  1  toggles on every frame_done.

Behaviour:
- Interface:
  - One clock, clk. Reset rst is synchronous and active-high.
  - Every output is registered. Reset values: axiov=0, axiod=0, axiir=1, frame_done=0, drop_err=0, led=0.
  - Reset mid-frame: frame is abandoned, no FCS is emitted, state returns to IDLE.
- States: IDLE, DATA, PAD, FCS, IFG. axiir=1 only in IDLE and DATA.
- IDLE:
  - CRC register = 32'hFFFFFFFF, dibit counter = 0.
  - axiiv high: accept the dibit, update the CRC, go to DATA.
- DATA:
  - Each accepted dibit: forwarded unchanged, CRC updated, counter += 1 (saturates at MAX_FRAME_DIBITS).
  - axiiv low ends the frame. Go to PAD if counter < 4*MIN_PAYLOAD_BYTES or counter mod 4 != 0; otherwise go to FCS.
  - A one-cycle gap in axiiv ends the frame; there is no glitch tolerance.
- PAD:
  - Emit 2'b00 dibits through the CRC. Continue until counter >= 4*MIN_PAYLOAD_BYTES and counter mod 4 == 0.
  - This also completes a partial byte when the input length is not byte aligned.
- FCS:
  - fcs = ~crc, frozen at FCS entry.
  - Emit 16 dibits; dibit k is {fcs[2k+1], fcs[2k]} for k = 0..15, so LSB goes first on the wire.
  - Then go to IFG and pulse frame_done.
- IFG:
  - axiov=0 for IFG_DIBITS cycles, then go to IDLE.
  - axiiv high during PAD/FCS/IFG: input is discarded and drop_err is set, sticky until rst.
- Latency and continuity:
  - axiov/axiod lag the input by exactly 1 cycle.
  - axiov is continuous from the first data dibit through the last FCS dibit, with no bubbles.
- CRC:
  - Reflected CRC-32, polynomial 32'hEDB88320.
  - Two serial steps per cycle: axiid[0] first, then axiid[1]. Step: fb = c[0]^bit; c = (c>>1) ^ (fb ? poly : 0).
- Boundaries:
  - Zero-length frame is impossible, since a frame needs at least one valid dibit.
  - Counter saturation does not stop forwarding.
  - axiiv rising on the last IFG cycle is dropped; it is accepted the next cycle in IDLE.

Decomposition:
- Package fcs_pkg holds:
  - state enum;
  - CRC32_POLY_REFL = 32'hEDB88320;
  - CRC32_INIT = 32'hFFFFFFFF;
  - CRC32_RESIDUE = 32'hDEBB20E3 (register value after the FCS, shared with the receive checker's bench);
  - FCS_DIBITS = 16.
- Sub-module crc32_dibit:
  - Combinational next-CRC function of (crc, dibit).
  - Reused by the framer and by verification models.

Test Plan:
1. MIN_PAYLOAD_BYTES=0, ASCII "123456789" (36 dibits) -> fcs 32'hCBF43926. FCS bytes 26 39 F4 CB. First four FCS dibits 2'b10, 2'b01, 2'b10, 2'b00. 52 consecutive valid dibits, frame_done on cycle 53 after first output, then 48 idle cycles.
2. Default params, 14-byte frame -> 46 bytes of zero pad (184 dibits of 2'b00), then 16 FCS dibits. Total valid = 256 dibits. Feeding the output bytes to a reference CRC yields residue 32'hDEBB20E3.
3. 61-byte frame, default params -> no padding; 244 data dibits + 16 FCS dibits.
4. 9 dibits (non-byte-aligned), MIN=0 -> 3 pad dibits 2'b00, then FCS over 3 bytes. drop_err stays 0.
5. axiiv reasserted 5 cycles into FCS -> axiir=0, input ignored, FCS unchanged, drop_err=1 and held until rst.
6. rst asserted at dibit 20 of DATA -> next cycle axiov=0, axiir=1. The following frame's FCS matches a fresh CRC, unaffected by the aborted frame.

Source files
------------

// File: rtl/fcs_pkg.sv
// fcs_pkg: shared state encoding and CRC-32 constants for the TX framer and its checkers
package fcs_pkg;
  typedef enum logic [2:0] {IDLE, DATA, PAD, FCS, IFG} state_t;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  localparam int FCS_DIBITS = 16;
endpackage

// File: rtl/crc32_dibit.sv
// crc32_dibit: next reflected CRC-32 register after one dibit, dibit[0] shifted in first
module crc32_dibit
  import fcs_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [1:0]  dibit,
  output logic [31:0] crc_nx
);
  logic [31:0] mid;
  always_comb begin
    mid = (crc >> 1) ^ ((crc[0] ^ dibit[0]) ? CRC32_POLY_REFL : 32'h0);
    crc_nx = (mid >> 1) ^ ((mid[0] ^ dibit[1]) ? CRC32_POLY_REFL : 32'h0);
  end
endmodule

// File: rtl/fcs_tx_framer.sv
// fcs_tx_framer: forwards an RMII TX dibit frame, zero-pads it, appends the CRC-32 FCS and enforces the IFG
module fcs_tx_framer
  import fcs_pkg::*;
#(
  parameter int MIN_PAYLOAD_BYTES = 60,
  parameter int IFG_DIBITS = 48,
  parameter int MAX_FRAME_DIBITS = 6072
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       axiiv,
  input  logic [1:0] axiid,
  output logic       axiir,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       frame_done,
  output logic       drop_err,
  output logic       led
);
  localparam int CW = $clog2(MAX_FRAME_DIBITS + IFG_DIBITS + FCS_DIBITS + 1);
  localparam logic [CW-1:0] MIN_D = CW'(4 * MIN_PAYLOAD_BYTES);
  localparam logic [CW-1:0] MAX_D = CW'(MAX_FRAME_DIBITS);
  localparam logic [CW-1:0] IFG_D = CW'(IFG_DIBITS);
  localparam logic [CW-1:0] FCS_D = CW'(FCS_DIBITS);
  state_t state;
  logic [31:0] crc, crc_src, crc_nx, fcs, sr;
  logic [1:0] dibit_src;
  logic [CW-1:0] cnt, cnt_inc;
  logic need_pad, fwd;
  always_comb begin
    fwd = state == IDLE || (state == DATA && axiiv);
    crc_src = state == IDLE ? CRC32_INIT : crc;
    dibit_src = fwd ? axiid : 2'b00;
    need_pad = cnt < MIN_D || cnt[1:0] != 2'b00;
    cnt_inc = cnt == MAX_D ? cnt : cnt + 1'b1;
    fcs = ~crc;
  end
  crc32_dibit u_crc (.crc(crc_src), .dibit(dibit_src), .crc_nx(crc_nx));
  // cnt is the frame dibit count until FCS entry, then reused as the FCS index and IFG timer
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      crc <= CRC32_INIT;
      sr <= '0;
      cnt <= '0;
      axiov <= 1'b0;
      axiod <= 2'b00;
      axiir <= 1'b1;
      frame_done <= 1'b0;
      drop_err <= 1'b0;
      led <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      drop_err <= drop_err | (axiiv & ~axiir);
      case (state)
        IDLE: begin
          axiov <= axiiv;
          axiod <= axiiv ? axiid : 2'b00;
          crc <= axiiv ? crc_nx : CRC32_INIT;
          cnt <= axiiv ? CW'(1) : '0;
          if (axiiv) state <= DATA;
        end
        DATA, PAD: begin
          if (fwd || need_pad) begin
            axiod <= dibit_src;
            crc <= crc_nx;
            cnt <= cnt_inc;
            if (!fwd) begin
              state <= PAD;
              axiir <= 1'b0;
            end
          end else begin
            axiod <= fcs[1:0];
            sr <= fcs >> 2;
            cnt <= CW'(1);
            state <= FCS;
            axiir <= 1'b0;
          end
        end
        FCS: begin
          if (cnt == FCS_D) begin
            axiov <= 1'b0;
            axiod <= 2'b00;
            frame_done <= 1'b1;
            led <= ~led;
            cnt <= CW'(1);
            state <= IFG;
          end else begin
            axiod <= sr[1:0];
            sr <= sr >> 2;
            cnt <= cnt + 1'b1;
          end
        end
        IFG: begin
          if (cnt == IFG_D) begin
            state <= IDLE;
            axiir <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fcs_tx_framer.sv
// tb_fcs_tx_framer: directed checks of padding, FCS, IFG, drop and reset behaviour on two framer configurations
module tb_fcs_tx_framer;
  typedef logic [1:0] dq_t[$];
  typedef byte bq_t[$];
  logic clk = 1'b0, rst = 1'b1, axiiv = 1'b0, sel = 1'b0;
  logic [1:0] axiid = 2'b00;
  logic ir0, ov0, fd0, de0, ld0, ir1, ov1, fd1, de1, ld1;
  logic [1:0] od0, od1;
  logic ir, ov, fd, de, ld;
  logic [1:0] od;
  int checks = 0, errors = 0;
  always #10 clk = ~clk;
  fcs_tx_framer #(.MIN_PAYLOAD_BYTES(0)) dut0 (
    .clk(clk), .rst(rst), .axiiv(axiiv & ~sel), .axiid(axiid), .axiir(ir0), .axiov(ov0),
    .axiod(od0), .frame_done(fd0), .drop_err(de0), .led(ld0));
  fcs_tx_framer dut1 (
    .clk(clk), .rst(rst), .axiiv(axiiv & sel), .axiid(axiid), .axiir(ir1), .axiov(ov1),
    .axiod(od1), .frame_done(fd1), .drop_err(de1), .led(ld1));
  always_comb begin
    ir = sel ? ir1 : ir0;
    ov = sel ? ov1 : ov0;
    od = sel ? od1 : od0;
    fd = sel ? fd1 : fd0;
    de = sel ? de1 : de0;
    ld = sel ? ld1 : ld0;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] crc_bits(input logic [31:0] c0, input dq_t d);
    logic [31:0] c = c0;
    foreach (d[i]) for (int b = 0; b < 2; b++) c = (c[0] ^ d[i][b]) ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    return c;
  endfunction
  function automatic dq_t to_dibits(input bq_t bs);
    dq_t q = {};
    foreach (bs[i]) for (int k = 0; k < 4; k++) q.push_back(2'(bs[i] >> (2 * k)));
    return q;
  endfunction
  function automatic dq_t expect_stream(input dq_t d, input int minb);
    dq_t q = d;
    logic [31:0] f;
    while (q.size() < 4 * minb || q.size() % 4 != 0) q.push_back(2'b00);
    f = ~crc_bits(32'hFFFFFFFF, q);
    for (int k = 0; k < 16; k++) q.push_back(f[2*k +: 2]);
    return q;
  endfunction
  task automatic run_frame(input dq_t din, input int inj, output dq_t got, output int lat, output int ncyc);
    dq_t g = {};
    int l = 0, n = 0;
    @(negedge clk);
    fork
      begin
        foreach (din[i]) begin
          @(posedge clk); #1 axiiv = 1'b1; axiid = din[i];
        end
        @(posedge clk); #1 axiiv = 1'b0; axiid = 2'b00;
        if (inj > 0) begin
          repeat (inj) @(posedge clk);
          #1 axiiv = 1'b1; axiid = 2'b11;
          check("ready_low_in_fcs", 32'(ir), 32'd0);
          repeat (3) @(posedge clk);
          #1 axiiv = 1'b0; axiid = 2'b00;
        end
      end
      begin
        int k = 0;
        do begin @(negedge clk); l++; end while (!ov && l < 20);
        while (ov && k < 8000) begin g.push_back(od); k++; @(negedge clk); end
        n = k + 1;
        check("frame_done_pulse", 32'(fd), 32'd1);
      end
    join
    got = g;
    lat = l;
    ncyc = n;
  endtask
  task automatic wait_ifg(output int n);
    int c = 0;
    while (!ir && c < 500) begin c++; @(negedge clk); end
    n = c;
  endtask
  task automatic cmp_stream(input string tag, input dq_t got, input dq_t exp);
    int bad = 0;
    for (int i = 0; i < got.size() && i < exp.size(); i++) if (got[i] !== exp[i]) bad++;
    check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
    check({tag, "_dibits"}, 32'(bad), 32'd0);
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    dq_t d, g, e;
    bq_t bs;
    int lat, nc, n, nz;
    logic [31:0] r;
    string s = "123456789";
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_axiov", 32'(ov), 32'd0);
    check("rst_axiod", 32'(od), 32'd0);
    check("rst_axiir", 32'(ir), 32'd1);
    check("rst_frame_done", 32'(fd), 32'd0);
    check("rst_drop_err", 32'(de), 32'd0);
    check("rst_led", 32'(ld), 32'd0);
    check("rst_axiir_dut1", 32'(ir1), 32'd1);
    rst = 1'b0;
    // "123456789" with no padding
    bs = {};
    for (int i = 0; i < 9; i++) bs.push_back(byte'(s[i]));
    d = to_dibits(bs);
    run_frame(d, 0, g, lat, nc);
    check("t1_latency", 32'(lat), 32'd2);
    check("t1_len", 32'(g.size()), 32'd52);
    check("t1_done_cycle", 32'(nc), 32'd53);
    r = '0;
    for (int k = 0; k < 16; k++) r[2*k +: 2] = g[36+k];
    check("t1_fcs", r, 32'hCBF43926);
    check("t1_fcs_d0", 32'(g[36]), 32'd2);
    check("t1_fcs_d1", 32'(g[37]), 32'd1);
    check("t1_fcs_d2", 32'(g[38]), 32'd2);
    check("t1_fcs_d3", 32'(g[39]), 32'd0);
    check("t1_led", 32'(ld), 32'd1);
    wait_ifg(n);
    check("t1_ifg_cycles", 32'(n), 32'd48);
    // 14-byte frame on the default configuration
    sel = 1'b1;
    bs = {};
    for (int i = 0; i < 14; i++) bs.push_back(byte'(i * 17 + 3));
    d = to_dibits(bs);
    e = expect_stream(d, 60);
    run_frame(d, 0, g, lat, nc);
    check("t2_len", 32'(g.size()), 32'd256);
    check("t2_latency", 32'(lat), 32'd2);
    nz = 0;
    for (int i = 56; i < 240 && i < g.size(); i++) if (g[i] != 2'b00) nz++;
    check("t2_pad_zero", 32'(nz), 32'd0);
    cmp_stream("t2", g, e);
    check("t2_residue", crc_bits(32'hFFFFFFFF, g), 32'hDEBB20E3);
    wait_ifg(n);
    // 61-byte frame needs no padding
    bs = {};
    for (int i = 0; i < 61; i++) bs.push_back(byte'(255 - 3 * i));
    d = to_dibits(bs);
    e = expect_stream(d, 60);
    run_frame(d, 0, g, lat, nc);
    check("t3_len", 32'(g.size()), 32'd260);
    cmp_stream("t3", g, e);
    wait_ifg(n);
    // 9 dibits, not byte aligned
    sel = 1'b0;
    d = {2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd3, 2'd1, 2'd2, 2'd1};
    e = expect_stream(d, 0);
    run_frame(d, 0, g, lat, nc);
    check("t4_len", 32'(g.size()), 32'd28);
    check("t4_pad", {26'd0, g[9], g[10], g[11]}, 32'd0);
    cmp_stream("t4", g, e);
    check("t4_drop_err", 32'(de), 32'd0);
    wait_ifg(n);
    // input reasserted during FCS is discarded
    d = to_dibits('{8'hDE, 8'hAD, 8'hBE, 8'hEF});
    e = expect_stream(d, 0);
    run_frame(d, 5, g, lat, nc);
    cmp_stream("t5", g, e);
    check("t5_drop_err", 32'(de), 32'd1);
    wait_ifg(n);
    d = {2'd3, 2'd0, 2'd1, 2'd2};
    e = expect_stream(d, 0);
    run_frame(d, 0, g, lat, nc);
    cmp_stream("t5b", g, e);
    check("t5_drop_err_sticky", 32'(de), 32'd1);
    wait_ifg(n);
    // reset at dibit 20 of a frame
    @(negedge clk);
    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1 axiiv = 1'b1; axiid = 2'(i);
    end
    @(posedge clk); #1 axiid = 2'b10; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; axiiv = 1'b0; axiid = 2'b00;
    @(negedge clk);
    check("t6_axiov", 32'(ov), 32'd0);
    check("t6_axiir", 32'(ir), 32'd1);
    check("t6_drop_err_clr", 32'(de), 32'd0);
    nz = 0;
    repeat (20) begin @(negedge clk); if (ov) nz++; end
    check("t6_no_fcs", 32'(nz), 32'd0);
    d = to_dibits('{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF});
    e = expect_stream(d, 0);
    run_frame(d, 0, g, lat, nc);
    cmp_stream("t6", g, e);
    check("t6_residue", crc_bits(32'hFFFFFFFF, g), 32'hDEBB20E3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
